controle_rodadas: RTL and testbench

CONTROLE_RODADAS -- requirements
Module: controle_rodadas

---
 rtl/controle_rodadas.sv | 176 +++++++++++++++++
 tb/tb_controle_rodadas.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/controle_rodadas.sv
// Round controller for the party game: setup, night action turns, vote turns and tally.
// Define CONTROLE_RODADAS_TIMEOUT_EN to auto-advance a turn after T_TURNO cycles without passa.
module controle_rodadas #(
  parameter int N_JOGADORES = 8,
  parameter int W_JOG       = $clog2(N_JOGADORES),
  parameter int W_RODADA    = 4,
  parameter int T_TURNO     = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   jogar,
  input  logic                   passa,
  input  logic [N_JOGADORES-1:0] vivo_mask,
  input  logic                   fim_jogo,
  output logic                   rst_global,
  output logic                   zera_CS,
  output logic                   e_seed_reg,
  output logic                   e_acao,
  output logic                   e_voto,
  output logic                   e_apura,
  output logic                   fase_noite,
  output logic                   fim,
  output logic [W_JOG-1:0]       jogador_atual,
  output logic [W_RODADA-1:0]    rodada,
  output logic [4:0]             db_estado,
  output logic                   db_timeout
);

  typedef enum logic [4:0] {
    INICIAL        = 5'd0,
    RESETA_TUDO    = 5'd1,
    PREPARA_JOGO   = 5'd2,
    ARMAZENA_JOGO  = 5'd3,
    PREPARA_JOGO_2 = 5'd4,
    PREPARA_NOITE  = 5'd5,
    TURNO_NOITE    = 5'd6,
    PREPARA_DIA    = 5'd7,
    TURNO_VOTO     = 5'd8,
    APURA          = 5'd9,
    FIM_JOGO       = 5'd10
  } estado_t;

  if (N_JOGADORES < 2 || N_JOGADORES > 32 || T_TURNO < 2) begin : g_param_invalido
    $error("controle_rodadas: parametros fora da faixa");
  end

  estado_t               estado, prox_estado;
  logic [W_JOG-1:0]      jogador_prox;
  logic [W_RODADA-1:0]   rodada_prox;
  logic [W_JOG-1:0]      primeiro_idx, seguinte_idx;
  logic                  tem_seguinte;
  logic                  vivo_atual, avanca, estouro, strobe, em_turno;

  // Lowest alive index overall, and lowest alive index above the current player.
  always_comb begin
    primeiro_idx = '0;
    seguinte_idx = '0;
    tem_seguinte = 1'b0;
    for (int i = N_JOGADORES - 1; i >= 0; i--) begin
      if (vivo_mask[i]) begin
        primeiro_idx = W_JOG'(i);
        if (i > int'(jogador_atual)) begin
          seguinte_idx = W_JOG'(i);
          tem_seguinte = 1'b1;
        end
      end
    end
  end

  assign vivo_atual = vivo_mask[jogador_atual];
  assign em_turno   = (estado == TURNO_NOITE) || (estado == TURNO_VOTO);

`ifdef CONTROLE_RODADAS_TIMEOUT_EN
  localparam int W_CNT = $clog2(T_TURNO);
  logic [W_CNT-1:0] cnt_turno;

  // passa in the expiry cycle takes precedence, so the slot ends with a strobe instead.
  assign estouro = vivo_atual && !passa && (cnt_turno == W_CNT'(T_TURNO - 1));

  always_ff @(posedge clock) begin
    if (reset || !em_turno || avanca) cnt_turno <= '0;
    else                              cnt_turno <= cnt_turno + 1'b1;
  end
`else
  assign estouro = 1'b0;
`endif

  // A dead current player is skipped without strobe even if passa is high.
  assign avanca = !vivo_atual || passa || estouro;
  assign strobe = vivo_atual && passa && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= INICIAL;
      jogador_atual <= '0;
      rodada        <= '0;
    end else begin
      estado        <= prox_estado;
      jogador_atual <= jogador_prox;
      rodada        <= rodada_prox;
    end
  end

  always_comb begin
    prox_estado  = estado;
    jogador_prox = jogador_atual;
    rodada_prox  = rodada;
    rst_global   = 1'b0;
    zera_CS      = 1'b0;
    e_seed_reg   = 1'b0;
    e_acao       = 1'b0;
    e_voto       = 1'b0;
    e_apura      = 1'b0;
    fase_noite   = 1'b0;
    fim          = 1'b0;
    db_timeout   = 1'b0;
    db_estado    = estado;
    case (estado)
      INICIAL: begin
        rst_global = 1'b1;
        zera_CS    = 1'b1;
        if (jogar) prox_estado = RESETA_TUDO;
      end
      RESETA_TUDO: begin
        rst_global  = 1'b1;
        zera_CS     = 1'b1;
        rodada_prox = '0;
        prox_estado = PREPARA_JOGO;
      end
      PREPARA_JOGO:   if (passa) prox_estado = ARMAZENA_JOGO;
      ARMAZENA_JOGO: begin
        e_seed_reg  = 1'b1;
        prox_estado = PREPARA_JOGO_2;
      end
      PREPARA_JOGO_2: prox_estado = PREPARA_NOITE;
      PREPARA_NOITE, PREPARA_DIA: begin
        fase_noite = (estado == PREPARA_NOITE);
        if (vivo_mask == '0) begin
          prox_estado = FIM_JOGO;
        end else begin
          jogador_prox = primeiro_idx;
          prox_estado  = (estado == PREPARA_NOITE) ? TURNO_NOITE : TURNO_VOTO;
        end
      end
      TURNO_NOITE, TURNO_VOTO: begin
        fase_noite = (estado == TURNO_NOITE);
        e_acao     = (estado == TURNO_NOITE) && strobe;
        e_voto     = (estado == TURNO_VOTO) && strobe;
        db_timeout = estouro && !reset;
        if (avanca) begin
          if (tem_seguinte)               jogador_prox = seguinte_idx;
          else if (estado == TURNO_NOITE) prox_estado  = PREPARA_DIA;
          else                            prox_estado  = APURA;
        end
      end
      APURA: begin
        e_apura = 1'b1;
        if (fim_jogo) begin
          prox_estado = FIM_JOGO;
        end else begin
          rodada_prox = (&rodada) ? rodada : rodada + 1'b1;
          prox_estado = PREPARA_NOITE;
        end
      end
      FIM_JOGO: begin
        fim = 1'b1;
        if (jogar) prox_estado = RESETA_TUDO;
      end
      default: begin
        db_estado   = 5'b11111;
        prox_estado = INICIAL;
      end
    endcase
  end

endmodule

// File: tb/tb_controle_rodadas.sv
// Directed bench for controle_rodadas (N=4, W_RODADA=2, T_TURNO=8).
module tb_controle_rodadas;
  logic       clock = 1'b0;
  logic       reset, jogar, passa, fim_jogo;
  logic [3:0] vivo_mask;
  logic       rst_global, zera_CS, e_seed_reg, e_acao, e_voto, e_apura;
  logic       fase_noite, fim, db_timeout;
  logic [1:0] jogador_atual, rodada;
  logic [4:0] db_estado;
  int         n_testes = 0;
  int         n_falhas = 0;

  controle_rodadas #(.N_JOGADORES(4), .W_RODADA(2), .T_TURNO(8)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .passa(passa),
    .vivo_mask(vivo_mask), .fim_jogo(fim_jogo),
    .rst_global(rst_global), .zera_CS(zera_CS), .e_seed_reg(e_seed_reg),
    .e_acao(e_acao), .e_voto(e_voto), .e_apura(e_apura),
    .fase_noite(fase_noite), .fim(fim), .jogador_atual(jogador_atual),
    .rodada(rodada), .db_estado(db_estado), .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_testes++;
    if (obs !== exp) begin
      n_falhas++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulso(input string tag, input logic noite);
    passa = 1'b1;
    #1;
    chk(tag, noite ? e_acao : e_voto, 1);
    tick();
    passa = 1'b0;
  endtask

  // From INICIAL or FIM_JOGO to PREPARA_NOITE.
  task automatic iniciar();
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    chk("estado_reseta", db_estado, 1);
    chk("rst_global_reseta", rst_global, 1);
    tick();
    chk("estado_prep_jogo", db_estado, 2);
    passa = 1'b1;
    tick();
    passa = 1'b0;
    chk("seed", e_seed_reg, 1);
    tick();
    chk("estado_prep2", db_estado, 4);
    tick();
    chk("estado_prep_noite", db_estado, 5);
    chk("fase_noite_prep", fase_noite, 1);
  endtask

  // One full round with vivo_mask 4'b1010, starting in PREPARA_NOITE.
  task automatic rodada_1010(input logic f, input int rod_esp);
    tick();
    chk("r_jog_noite1", jogador_atual, 1);
    pulso("r_acao1", 1'b1);
    chk("r_jog_noite3", jogador_atual, 3);
    pulso("r_acao3", 1'b1);
    chk("r_estado_dia", db_estado, 7);
    tick();
    chk("r_jog_voto1", jogador_atual, 1);
    pulso("r_voto1", 1'b0);
    pulso("r_voto3", 1'b0);
    chk("r_estado_apura", db_estado, 9);
    chk("r_e_apura", e_apura, 1);
    fim_jogo = f;
    tick();
    fim_jogo = 1'b0;
    if (f) begin
      chk("r_estado_fim", db_estado, 10);
    end else begin
      chk("r_estado_noite", db_estado, 5);
      chk("r_rodada", rodada, rod_esp);
      chk("r_apura_um_ciclo", e_apura, 0);
    end
  endtask

  initial begin
    reset = 1'b1; jogar = 1'b0; passa = 1'b0; fim_jogo = 1'b0; vivo_mask = 4'b1111;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_estado", db_estado, 0);
    chk("rst_rst_global", rst_global, 1);
    chk("rst_zera_CS", zera_CS, 1);
    chk("rst_jog", jogador_atual, 0);
    chk("rst_rodada", rodada, 0);
    chk("rst_e_acao", e_acao, 0);
    chk("rst_e_voto", e_voto, 0);
    chk("rst_e_apura", e_apura, 0);
    chk("rst_seed", e_seed_reg, 0);
    chk("rst_fase_noite", fase_noite, 0);
    chk("rst_fim", fim, 0);
    chk("rst_timeout", db_timeout, 0);
    passa = 1'b1;
    tick();
    passa = 1'b0;
    chk("inicial_espera_jogar", db_estado, 0);

    // Night with all four alive.
    iniciar();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("noite_jog", jogador_atual, k);
      pulso("noite_acao", 1'b1);
    end
    chk("noite_para_dia", db_estado, 7);
    chk("dia_fase_noite", fase_noite, 0);
    tick();
    chk("voto_estado", db_estado, 8);
    chk("voto_jog0", jogador_atual, 0);

    // Player 2 dies during own vote turn.
    pulso("voto0", 1'b0);
    pulso("voto1", 1'b0);
    chk("voto_jog2", jogador_atual, 2);
    vivo_mask = 4'b1011;
    passa = 1'b1;
    #1;
    chk("morto_sem_voto", e_voto, 0);
    tick();
    passa = 1'b0;
    vivo_mask = 4'b1111;
    chk("morto_pulado", jogador_atual, 3);
    pulso("voto3", 1'b0);
    chk("apura_estado", db_estado, 9);
    chk("apura_strobe", e_apura, 1);
    tick();
    chk("apura_rodada1", rodada, 1);

    // Reset mid-turn with passa high.
    tick();
    chk("turno_antes_reset", db_estado, 6);
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    chk("jogar_ignorado", db_estado, 6);
    reset = 1'b1;
    passa = 1'b1;
    #1;
    chk("reset_sem_acao", e_acao, 0);
    tick();
    reset = 1'b0;
    passa = 1'b0;
    chk("pos_reset_estado", db_estado, 0);
    chk("pos_reset_acao", e_acao, 0);
    chk("pos_reset_rst_global", rst_global, 1);
    chk("pos_reset_rodada", rodada, 0);

    // Sparse mask, rodada saturation, then game over.
    vivo_mask = 4'b1010;
    iniciar();
    rodada_1010(1'b0, 1);
    rodada_1010(1'b0, 2);
    rodada_1010(1'b0, 3);
    rodada_1010(1'b0, 3);
    rodada_1010(1'b0, 3);
    rodada_1010(1'b1, 0);
    chk("fim_saida", fim, 1);
    tick();
    chk("fim_mantem", db_estado, 10);

    // Restart, then empty mask in PREPARA_NOITE ends the game.
    vivo_mask = 4'b0000;
    iniciar();
    tick();
    chk("mask_vazia_fim", db_estado, 10);

`ifdef CONTROLE_RODADAS_TIMEOUT_EN
    vivo_mask = 4'b1111;
    iniciar();
    tick();
    for (int c = 0; c < 7; c++) begin
      chk("to_sem_pulso", db_timeout, 0);
      tick();
    end
    chk("to_pulso", db_timeout, 1);
    chk("to_sem_acao", e_acao, 0);
    tick();
    chk("to_avanca", jogador_atual, 1);
    chk("to_um_ciclo", db_timeout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end
endmodule
